// File: rtl/branch_resolve_pkg.sv
// Shared types for LEGv8 branch resolution: branch kinds, condition codes,
// the NZCV flag layout and the B.cond evaluator.
package branch_pkg;

    typedef enum logic [1:0] {
        BR_NONE  = 2'd0,
        BR_B     = 2'd1,
        BR_CBZ   = 2'd2,
        BR_BCOND = 2'd3
    } br_type_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_REDIR = 1'b1
    } br_state_e;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    // Unlisted condition codes resolve to not-taken.
    function automatic logic cond_holds(input logic [3:0] cond, input nzcv_t f);
        logic result;
        result = 1'b0;
        case (cond)
            COND_EQ: result = f.z;
            COND_NE: result = ~f.z;
            COND_GE: result = (f.n == f.v);
            COND_LT: result = (f.n != f.v);
            COND_GT: result = ~f.z & (f.n == f.v);
            COND_LE: result = f.z | (f.n != f.v);
            COND_AL: result = 1'b1;
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Execute-stage to branch-resolver bundle; the resolver side is the slave.
interface branch_resolve_if #(parameter int OFF_W = 26);
    logic             ex_valid;
    logic             ex_setFlags;
    logic             alu_neg;
    logic             alu_zero;
    logic             alu_ovf;
    logic             alu_cout;
    logic [1:0]       ex_brType;
    logic [3:0]       ex_cond;
    logic [63:0]      ex_pc;
    logic [OFF_W-1:0] ex_imm;
    logic [3:0]       flags_q;
    logic             redirect;
    logic [63:0]      redirect_pc;
    logic             squash;

    modport master (
        output ex_valid, ex_setFlags, alu_neg, alu_zero, alu_ovf, alu_cout,
               ex_brType, ex_cond, ex_pc, ex_imm,
        input  flags_q, redirect, redirect_pc, squash
    );

    modport slave (
        input  ex_valid, ex_setFlags, alu_neg, alu_zero, alu_ovf, alu_cout,
               ex_brType, ex_cond, ex_pc, ex_imm,
        output flags_q, redirect, redirect_pc, squash
    );
endinterface

// File: rtl/branch_resolve_nzcv_reg.sv
// Architectural NZCV flag register: 4-bit enabled register, synchronous reset.
module nzcv_reg
    import branch_pkg::*;
(
    input  logic  clk,
    input  logic  srst,
    input  logic  en,
    input  nzcv_t d,
    output nzcv_t q
);

    nzcv_t q_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            q_reg <= '0;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/branch_resolve.sv
// Resolves B / CBZ / B.cond in execute and issues a registered one-cycle
// PC redirect plus squash of the wrong-path instruction behind it.
module branch_resolve
    import branch_pkg::*;
#(
    parameter int OFF_W = 26
) (
    input  logic             clk,
    input  logic             reset,
    branch_resolve_if.slave  bus
);

    br_state_e        state_reg;
    logic             redirect_reg;
    logic             squash_reg;
    logic [63:0]      redirect_pc_reg;

    logic             live;
    logic             flag_we;
    logic             taken;
    logic [OFF_W-1:0] imm;
    logic [63:0]      offset_b;
    logic [63:0]      offset_19;
    logic [63:0]      target;
    nzcv_t            flags_new;
    nzcv_t            flags_cur;

    // The instruction behind a taken branch is wrong-path: it neither
    // writes flags nor branches.
    assign live    = bus.ex_valid & ~squash_reg;
    assign flag_we = live & bus.ex_setFlags;

    assign flags_new = '{n: bus.alu_neg, z: bus.alu_zero, c: bus.alu_cout, v: bus.alu_ovf};

    nzcv_reg u_flags (
        .clk  (clk),
        .srst (reset),
        .en   (flag_we),
        .d    (flags_new),
        .q    (flags_cur)
    );

    // B.cond reads the flags as registered, so a branch that also sets
    // flags sees the previous values.
    always_comb begin
        taken = 1'b0;
        case (br_type_e'(bus.ex_brType))
            BR_B:     taken = 1'b1;
            BR_CBZ:   taken = bus.alu_zero;
            BR_BCOND: taken = cond_holds(bus.ex_cond, flags_cur);
            default:  taken = 1'b0;
        endcase
    end

    assign imm       = bus.ex_imm;
    assign offset_b  = {{36{imm[25]}}, imm[25:0], 2'b00};
    assign offset_19 = {{43{imm[18]}}, imm[18:0], 2'b00};

    always_comb begin
        target = bus.ex_pc + offset_19;
        if (br_type_e'(bus.ex_brType) == BR_B) begin
            target = bus.ex_pc + offset_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_RUN;
            redirect_reg    <= 1'b0;
            squash_reg      <= 1'b0;
            redirect_pc_reg <= '0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (live && taken) begin
                        state_reg       <= ST_REDIR;
                        redirect_reg    <= 1'b1;
                        squash_reg      <= 1'b1;
                        redirect_pc_reg <= target;
                    end else begin
                        redirect_reg <= 1'b0;
                        squash_reg   <= 1'b0;
                    end
                end
                ST_REDIR: begin
                    state_reg    <= ST_RUN;
                    redirect_reg <= 1'b0;
                    squash_reg   <= 1'b0;
                end
                default: begin
                    state_reg    <= ST_RUN;
                    redirect_reg <= 1'b0;
                    squash_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.flags_q     = flags_cur;
    assign bus.redirect    = redirect_reg;
    assign bus.squash      = squash_reg;
    assign bus.redirect_pc = redirect_pc_reg;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed vectors for branch_resolve; driver queues expected post-edge
// outputs, a separate monitor pops and compares after each rising edge.
module tb_branch_resolve;
    import branch_pkg::*;

    typedef struct {
        int          id;
        logic        redirect;
        logic        squash;
        logic [63:0] pc;
        logic [3:0]  flags;
    } exp_t;

    logic clk;
    logic reset;
    exp_t exp_q[$];
    int   vectors;
    int   miscompares;
    int   next_id;

    branch_resolve_if #(.OFF_W(26)) bus ();

    branch_resolve #(.OFF_W(26)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input int id, input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL vec %0d %s: got 0x%0h, expected 0x%0h", id, name, act, req);
        end
    endtask

    // Monitor: the DUT presents new outputs after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.id, "redirect",    {63'd0, bus.redirect}, {63'd0, e.redirect});
                chk(e.id, "squash",      {63'd0, bus.squash},   {63'd0, e.squash});
                chk(e.id, "redirect_pc", bus.redirect_pc,       e.pc);
                chk(e.id, "flags_q",     {60'd0, bus.flags_q},  {60'd0, e.flags});
                $display("vec %0d: redirect=%0b squash=%0b redirect_pc=0x%0h flags=%4b",
                         e.id, bus.redirect, bus.squash, bus.redirect_pc, bus.flags_q);
            end
        end
    end

    task automatic push_exp(input logic r, input logic s, input logic [63:0] pc, input logic [3:0] f);
        exp_t e;
        e.id = next_id; e.redirect = r; e.squash = s; e.pc = pc; e.flags = f;
        exp_q.push_back(e);
        next_id++;
    endtask

    // One cycle of stimulus; expectations describe outputs after the next edge.
    task automatic drv(input logic rst, input logic v, input logic sf,
                       input logic n, input logic z, input logic c, input logic o,
                       input logic [1:0] bt, input logic [3:0] cond,
                       input logic [63:0] pc, input logic [25:0] imm,
                       input logic er, input logic es, input logic [63:0] epc, input logic [3:0] ef);
        @(negedge clk);
        reset = rst;
        bus.ex_valid = v; bus.ex_setFlags = sf;
        bus.alu_neg = n; bus.alu_zero = z; bus.alu_cout = c; bus.alu_ovf = o;
        bus.ex_brType = bt; bus.ex_cond = cond; bus.ex_pc = pc; bus.ex_imm = imm;
        push_exp(er, es, epc, ef);
    endtask

    task automatic idle(input logic [63:0] epc, input logic [3:0] ef);
        drv(0, 0, 0, 0, 0, 0, 0, 2'd0, 4'h0, 64'h0, 26'h0, 0, 0, epc, ef);
    endtask

    task automatic rand_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.ex_valid = 1'($urandom); bus.ex_setFlags = 1'($urandom);
        bus.alu_neg = 1'($urandom); bus.alu_zero = 1'($urandom);
        bus.alu_cout = 1'($urandom); bus.alu_ovf = 1'($urandom);
        bus.ex_brType = 2'($urandom); bus.ex_cond = 4'($urandom);
        bus.ex_pc = {$urandom, $urandom}; bus.ex_imm = 26'($urandom);
        push_exp(0, 0, 64'h0, 4'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int wait_cycles;
        vectors = 0; miscompares = 0; next_id = 0;
        reset = 1'b1;
        bus.ex_valid = 0; bus.ex_setFlags = 0; bus.alu_neg = 0; bus.alu_zero = 0;
        bus.alu_cout = 0; bus.alu_ovf = 0; bus.ex_brType = 0; bus.ex_cond = 0;
        bus.ex_pc = 0; bus.ex_imm = 0;

        rand_reset();
        rand_reset();
        idle(64'h0, 4'h0);

        // B backwards by one word, then a wrong-path B in the squash cycle
        drv(0, 1, 0, 0, 0, 0, 0, 2'd1, 4'h0, 64'h100, 26'h3FFFFFF, 1, 1, 64'hFC, 4'h0);
        drv(0, 1, 0, 0, 0, 0, 0, 2'd1, 4'h0, 64'h200, 26'h5,       0, 0, 64'hFC, 4'h0);
        idle(64'hFC, 4'h0);

        // CBZ taken / not taken
        drv(0, 1, 0, 0, 1, 0, 0, 2'd2, 4'h0, 64'h2000, 26'h10, 1, 1, 64'h2040, 4'h0);
        idle(64'h2040, 4'h0);
        drv(0, 1, 0, 0, 0, 0, 0, 2'd2, 4'h0, 64'h2000, 26'h10, 0, 0, 64'h2040, 4'h0);

        // SUBS -> N=1, then B.cond variants
        drv(0, 1, 1, 1, 0, 0, 0, 2'd0, 4'h0, 64'h2004, 26'h0, 0, 0, 64'h2040, 4'h8);
        drv(0, 1, 0, 0, 0, 0, 0, 2'd3, COND_LT, 64'h3000, 26'h4, 1, 1, 64'h3010, 4'h8);
        idle(64'h3010, 4'h8);
        drv(0, 1, 0, 0, 0, 0, 0, 2'd3, COND_GE, 64'h3000, 26'h4, 0, 0, 64'h3010, 4'h8);
        drv(0, 1, 0, 0, 0, 0, 0, 2'd3, COND_AL, 64'h4000, 26'h0FFFFFF, 1, 1, 64'h3FFC, 4'h8);
        idle(64'h3FFC, 4'h8);
        drv(0, 1, 0, 0, 0, 0, 0, 2'd3, 4'hF,    64'h5000, 26'h4, 0, 0, 64'h3FFC, 4'h8);
        drv(0, 1, 0, 0, 0, 0, 0, 2'd3, COND_EQ, 64'h5000, 26'h4, 0, 0, 64'h3FFC, 4'h8);
        drv(0, 1, 0, 0, 0, 0, 0, 2'd3, COND_NE, 64'h5000, 26'h1, 1, 1, 64'h5004, 4'h8);
        idle(64'h5004, 4'h8);

        // Z=1,C=1 set, taken B, squashed SUBS must not overwrite the flags
        drv(0, 1, 1, 0, 1, 1, 0, 2'd0, 4'h0, 64'h5100, 26'h0, 0, 0, 64'h5004, 4'h6);
        drv(0, 1, 0, 0, 0, 0, 0, 2'd1, 4'h0, 64'h6000, 26'h2, 1, 1, 64'h6008, 4'h6);
        drv(0, 1, 1, 1, 0, 0, 0, 2'd0, 4'h0, 64'h6004, 26'h0, 0, 0, 64'h6008, 4'h6);
        drv(0, 1, 0, 0, 0, 0, 0, 2'd3, COND_EQ, 64'h7000, 26'h3, 1, 1, 64'h700C, 4'h6);
        idle(64'h700C, 4'h6);
        drv(0, 1, 0, 0, 0, 0, 0, 2'd3, COND_GT, 64'h7100, 26'h1, 0, 0, 64'h700C, 4'h6);
        drv(0, 1, 0, 0, 0, 0, 0, 2'd3, COND_LE, 64'h7200, 26'h1, 1, 1, 64'h7204, 4'h6);
        idle(64'h7204, 4'h6);

        // Flag-setting B.EQ: new flags are written, branch uses old Z=1
        drv(0, 1, 1, 0, 0, 0, 0, 2'd3, COND_EQ, 64'h8000, 26'h1, 1, 1, 64'h8004, 4'h0);
        idle(64'h8004, 4'h0);

        // CBZ ignores immediate bits above bit 18
        drv(0, 1, 0, 0, 1, 0, 0, 2'd2, 4'h0, 64'h9000, 26'h2000010, 1, 1, 64'h9040, 4'h0);
        idle(64'h9040, 4'h0);

        // Wrapping target, then reset during the redirect cycle
        drv(0, 1, 1, 1, 0, 0, 0, 2'd1, 4'h0, 64'hFFFF_FFFF_FFFF_FFFC, 26'h1, 1, 1, 64'h0, 4'h8);
        drv(1, 1, 0, 0, 0, 0, 0, 2'd1, 4'h0, 64'h100, 26'h1, 0, 0, 64'h0, 4'h0);
        idle(64'h0, 4'h0);

        // Reset dominates a live taken branch
        drv(1, 1, 1, 1, 1, 1, 1, 2'd1, 4'h0, 64'h100, 26'h1, 0, 0, 64'h0, 4'h0);
        idle(64'h0, 4'h0);

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            #2;
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Resolves LEGv8 control flow for the single-cycle/pipelined CPU. Holds the architectural NZCV flag register written by flag-setting ALU ops and evaluates B, CBZ and B.cond. It produces a registered PC redirect and a one-cycle squash of the wrong-path instruction. It sits between the execute-stage ALU (flags, zero result) and the fetch-stage PC mux.

## Interface
- OFF_W, default 26: width of the raw immediate field; the B offset uses all 26 bits, CBZ and B.cond use the low 19 bits.
- clk, input, 1: rising-edge clock for all state.
- reset, input, 1: synchronous, active-high; sampled on the rising edge of clk.
- ex_valid, input, 1: the execute slot holds a real instruction.
- ex_setFlags, input, 1: the instruction writes NZCV (ADDS/SUBS).
- alu_neg, alu_zero, alu_ovf, alu_cout, input, 1 each: ALU result flags. alu_zero is the 64-input zero detect of the ALU result.
- ex_brType, input, 2: 0 NONE, 1 B, 2 CBZ, 3 BCOND.
- ex_cond, input, 4: B.cond condition code. Supported codes are EQ=0, NE=1, GE=A, LT=B, GT=C, LE=D, AL=E.
- ex_pc, input, 64: PC of the execute-slot instruction.
- ex_imm, input, OFF_W: raw branch immediate, not yet sign-extended or shifted.
- flags_q, output, 4: registered {N,Z,C,V}.
- redirect, output, 1: registered; the PC mux loads redirect_pc this cycle.
- redirect_pc, output, 64: registered branch target.
- squash, output, 1: registered; the execute-slot instruction is wrong-path and is killed.

## Operation
- The live instruction is `live = ex_valid & ~squash`. Squashed instructions never write flags and never branch.
- Flag write: on `live & ex_setFlags`, at the edge, flags_q <= {alu_neg, alu_zero, alu_cout, alu_ovf}. Otherwise flags_q holds.
- Taken decision, computed in the cycle the instruction is live:
  - B: always taken.
  - CBZ: taken when alu_zero=1. The ALU passes Rt through.
  - BCOND: evaluated on flags_q as it stands at the start of the cycle:
    - EQ: Z.
    - NE: ~Z.
    - GE: N==V.
    - LT: N!=V.
    - GT: ~Z & N==V.
    - LE: Z | N!=V.
    - AL: 1.
    - Any other code: not taken.
  - NONE: not taken.
- A flag-setting instruction in cycle t is visible to a B.cond in cycle t+1 through flags_q. No bypass is needed. A single instruction never both sets flags and branches. If ex_setFlags is asserted with brType≠NONE, the flag write still happens and the branch uses the old flags_q.
- Target: `pc + (sext(imm) << 2)`, computed modulo 2^64 with no overflow detection.
  - B sign-extends imm[25:0].
  - CBZ and BCOND sign-extend imm[18:0].
- State machine:
  - RUN: a live taken branch moves the block to REDIR at the edge and loads redirect_pc.
  - REDIR: redirect=1 and squash=1 for exactly one cycle, then return to RUN unconditionally. A branch arriving in REDIR is squashed and ignored.
  - Back-to-back taken branches are therefore impossible. The second is always on the wrong path.
- Reset values: state=RUN, flags_q=0000, redirect=0, squash=0, redirect_pc=0.
- Reset mid-operation: asserted in REDIR, the pending redirect is dropped and the outputs are at reset values the next cycle. Reset dominates all other inputs.

## Timing
- Taken-branch latency is 1 cycle: branch live at edge t gives redirect/squash high during cycle t+1, and the PC loads at edge t+2.
- Flag-write latency is 1 cycle. flags_q changes only at rising edges.
- Not-taken branches add no bubble and produce no output change.
- All outputs are driven from flops, with no combinational input-to-output path.

## Structure
- The shared package `branch_pkg` holds:
  - the brType encoding as an enum;
  - the condition-code constants (EQ, NE, GE, LT, GT, LE, AL);
  - a NZCV struct with bit order {N,Z,C,V}.
- The sub-module `nzcv_reg` is a 4-bit enabled register with synchronous reset. The remainder covers:
  - the condition evaluator;
  - the sign-extend/shift adder for the target;
  - the two-state FSM.

## Test plan
- Reset: hold reset 2 cycles with random inputs -> flags_q=0000, redirect=0, squash=0, redirect_pc=0.
- B: pc=0x100, imm=0x3FFFFFF (−1) -> redirect=1 and redirect_pc=0xFC one cycle later. The next-cycle instruction, given as B imm=5, is squashed with no second redirect.
- CBZ:
  - pc=0x2000, imm19=0x10, alu_zero=1 -> redirect_pc=0x2040.
  - The same with alu_zero=0 -> no redirect.
- Flags then B.cond: SUBS sets {N=1,Z=0,C=0,V=0}. The next cycle B.LT taken and B.GE not taken. With an AL code -> taken. With code 0xF -> not taken.
- Squashed flag write: a SUBS sets Z=1, then a taken B, then in the squash cycle a SUBS with alu_zero=0 -> flags_q keeps Z=1.
- Reset in REDIR: a taken B, then reset asserted during the redirect cycle -> next cycle redirect=0 and squash=0. The target wraps from 0xFFFF_FFFF_FFFF_FFFC with imm=+1 to 0x0.
